// File: rtl/store_align_buf.sv
// Store alignment buffer: queues LSU stores and issues them as byte-lane RAM beats,
// splitting stores that straddle a RAM word boundary into two consecutive beats.
module store_align_buf #(
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [AW-1:0]   req_addr,
    input  logic [1:0]      req_size,
    input  logic [DW-1:0]   req_wdata,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic [AW-1:0]   mem_addr,
    output logic [DW/8-1:0] mem_we,
    output logic [DW-1:0]   mem_wdata,
    output logic            empty
);

    localparam int unsigned NB = DW / 8;
    localparam int unsigned OB = $clog2(NB);
    localparam int unsigned PW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StBeat0, StBeat1} state_e;

    // Two-word-wide byte mask and data for one store, packed as {mask2, data2}.
    function automatic logic [2*NB+2*DW-1:0] align(input logic [AW-1:0] a,
                                                   input logic [1:0]    s,
                                                   input logic [DW-1:0] d);
        logic [1:0]      sz;
        logic [OB-1:0]   off;
        logic [2*NB-1:0] m;
        logic [2*DW-1:0] x;
        sz  = (DW == 32 && s == 2'd3) ? 2'd2 : s;
        off = a[OB-1:0];
        case (sz)
            2'd0:    m = (2*NB)'(1);
            2'd1:    m = (2*NB)'(3);
            2'd2:    m = (2*NB)'(15);
            default: m = (2*NB)'(255);
        endcase
        m = m << off;
        x = {{DW{1'b0}}, d} << (8 * off);
        // Drop data bits above the access size.
        for (int i = 0; i < 2 * NB; i++) begin
            if (!m[i]) x[8*i +: 8] = 8'h00;
        end
        return {m, x};
    endfunction

    logic [AW-1:0] fifo_addr [DEPTH];
    logic [1:0]    fifo_size [DEPTH];
    logic [DW-1:0] fifo_data [DEPTH];

    logic [PW-1:0] rd_ptr_q, wr_ptr_q, rd_nxt;
    logic [PW:0]   count_q;
    state_e        state_q, state_d;

    logic            valid_q;
    logic [AW-1:0]   addr_q;
    logic [NB-1:0]   we_q, hi_we_q;
    logic [DW-1:0]   wdata_q, hi_wdata_q;

    logic            push, hs, pop, load, load_hi;
    logic [AW-1:0]   src_addr;
    logic [1:0]      src_size;
    logic [DW-1:0]   src_data;
    logic [2*NB+2*DW-1:0] al;
    logic [2*NB-1:0] al_mask;
    logic [2*DW-1:0] al_data;

    assign req_ready = (count_q != (PW+1)'(DEPTH));
    assign push      = req_valid & req_ready;
    assign hs        = valid_q & mem_ready;
    // A beat with a pending high half does not retire the entry.
    assign pop       = hs & ~load_hi;
    assign rd_nxt    = rd_ptr_q + PW'(1);

    assign mem_valid = valid_q;
    assign mem_addr  = addr_q;
    assign mem_we    = we_q;
    assign mem_wdata = wdata_q;
    assign empty     = (count_q == '0) && (state_q == StIdle);

    // Request storage; entries need no reset since count gates their use.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr_q] <= req_addr;
            fifo_size[wr_ptr_q] <= req_size;
            fifo_data[wr_ptr_q] <= req_wdata;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_nxt;
            count_q <= count_q + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    // Next-state and choice of which store feeds the next beat0.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        load_hi  = 1'b0;
        src_addr = fifo_addr[rd_ptr_q];
        src_size = fifo_size[rd_ptr_q];
        src_data = fifo_data[rd_ptr_q];
        case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    load = 1'b1;
                end else if (push) begin
                    // Empty buffer: take the incoming store straight away.
                    load     = 1'b1;
                    src_addr = req_addr;
                    src_size = req_size;
                    src_data = req_wdata;
                end
            end
            StBeat0, StBeat1: begin
                if (hs) begin
                    if (state_q == StBeat0 && |hi_we_q) begin
                        load_hi = 1'b1;
                        state_d = StBeat1;
                    end else if (count_q > (PW+1)'(1)) begin
                        load     = 1'b1;
                        src_addr = fifo_addr[rd_nxt];
                        src_size = fifo_size[rd_nxt];
                        src_data = fifo_data[rd_nxt];
                    end else if (push) begin
                        // Entry being written now becomes the head after this pop.
                        load     = 1'b1;
                        src_addr = req_addr;
                        src_size = req_size;
                        src_data = req_wdata;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (load) state_d = StBeat0;
    end

    assign al      = align(src_addr, src_size, src_data);
    assign al_mask = al[2*NB+2*DW-1 -: 2*NB];
    assign al_data = al[2*DW-1:0];

    // Registered beat outputs; the high half is parked until beat0 is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            valid_q    <= 1'b0;
            addr_q     <= '0;
            we_q       <= '0;
            wdata_q    <= '0;
            hi_we_q    <= '0;
            hi_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                valid_q    <= 1'b1;
                addr_q     <= src_addr & ~AW'(NB - 1);
                we_q       <= al_mask[NB-1:0];
                wdata_q    <= al_data[DW-1:0];
                hi_we_q    <= al_mask[2*NB-1:NB];
                hi_wdata_q <= al_data[2*DW-1:DW];
            end else if (load_hi) begin
                addr_q  <= addr_q + AW'(NB);
                we_q    <= hi_we_q;
                wdata_q <= hi_wdata_q;
                hi_we_q <= '0;
            end else if (hs) begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_store_align_buf.sv
// Bench for store_align_buf: a 32-bit and a 64-bit instance, each with a byte-level
// reference model feeding an expected-beat queue that a negedge monitor drains.
module tb_store_align_buf;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  we;
        logic [63:0] wdata;
    } beat_t;

    logic clk = 1'b0;
    logic rst;

    logic        rv32, rr32, mv32, rdy32, e32;
    logic [31:0] ra32, ma32, rd32, mwd32;
    logic [1:0]  rs32;
    logic [3:0]  mwe32;

    logic        rv64, rr64, mv64, rdy64, e64;
    logic [31:0] ra64, ma64;
    logic [1:0]  rs64;
    logic [63:0] rd64, mwd64;
    logic [7:0]  mwe64;

    beat_t q32[$];
    beat_t q64[$];
    int    checks = 0;
    int    errors = 0;
    bit    rand_rdy = 1'b0;

    always #5 clk = ~clk;

    store_align_buf #(.DW(32), .AW(32), .DEPTH(4)) dut32 (
        .clk(clk), .rst(rst), .req_valid(rv32), .req_ready(rr32), .req_addr(ra32),
        .req_size(rs32), .req_wdata(rd32), .mem_valid(mv32), .mem_ready(rdy32),
        .mem_addr(ma32), .mem_we(mwe32), .mem_wdata(mwd32), .empty(e32)
    );

    store_align_buf #(.DW(64), .AW(32), .DEPTH(4)) dut64 (
        .clk(clk), .rst(rst), .req_valid(rv64), .req_ready(rr64), .req_addr(ra64),
        .req_size(rs64), .req_wdata(rd64), .mem_valid(mv64), .mem_ready(rdy64),
        .mem_addr(ma64), .mem_we(mwe64), .mem_wdata(mwd64), .empty(e64)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: scatter each store byte to its own RAM word and lane.
    task automatic expect_store(input bit w, input logic [31:0] a, input logic [1:0] sz,
                                input logic [63:0] d);
        int          nb, n, lane;
        logic [31:0] ba, wa;
        beat_t       b0, b1;
        bit          has1;
        nb   = w ? 8 : 4;
        n    = 1 << sz;
        if (!w && n == 8) n = 4;
        b0   = '{addr: a & ~32'(nb - 1), we: 8'h00, wdata: 64'h0};
        b1   = '{addr: 32'h0, we: 8'h00, wdata: 64'h0};
        has1 = 1'b0;
        for (int k = 0; k < n; k++) begin
            ba   = a + 32'(k);
            wa   = ba & ~32'(nb - 1);
            lane = int'(ba[2:0]) % nb;
            if (wa == b0.addr) begin
                b0.we[lane]          = 1'b1;
                b0.wdata[8*lane +: 8] = d[8*k +: 8];
            end else begin
                has1                  = 1'b1;
                b1.addr               = wa;
                b1.we[lane]           = 1'b1;
                b1.wdata[8*lane +: 8] = d[8*k +: 8];
            end
        end
        if (w) begin
            q64.push_back(b0);
            if (has1) q64.push_back(b1);
        end else begin
            q32.push_back(b0);
            if (has1) q32.push_back(b1);
        end
    endtask

    // Present one request and hold it until accepted; returns #1 after the accepting edge.
    task automatic send(input bit w, input logic [31:0] a, input logic [1:0] sz,
                        input logic [63:0] d);
        bit acc = 1'b0;
        int n   = 0;
        if (w) begin
            rv64 = 1'b1; ra64 = a; rs64 = sz; rd64 = d;
        end else begin
            rv32 = 1'b1; ra32 = a; rs32 = sz; rd32 = d[31:0];
        end
        while (!acc && n < 300) begin
            @(negedge clk);
            acc = w ? rr64 : rr32;
            if (acc) expect_store(w, a, sz, d);
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no req_ready required req_ready=1 (dut%0d)",
                     w ? 64 : 32);
        end
        if (w) rv64 = 1'b0;
        else   rv32 = 1'b0;
    endtask

    task automatic rand_run(input bit w, input int cnt);
        logic [31:0] a;
        logic [1:0]  sz;
        logic [63:0] d;
        for (int i = 0; i < cnt; i++) begin
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFF8 | 32'($urandom_range(0, 7));
            sz = 2'($urandom_range(0, 3));
            d  = {$urandom, $urandom};
            send(w, a, sz, d);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q32.size() != 0 || q64.size() != 0) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_q32", 64'(q32.size()), 64'd0);
        chk("drain_q64", 64'(q64.size()), 64'd0);
    endtask

    // Monitor: every presented beat must match the queue head; popped on handshake.
    always @(negedge clk) begin
        beat_t e;
        if (!rst && mv32) begin
            checks++;
            if (q32.size() == 0) begin
                errors++;
                $display("FAIL beat32_unexpected: got addr=%h we=%b data=%h required none",
                         ma32, mwe32, mwd32);
            end else begin
                e = rdy32 ? q32.pop_front() : q32[0];
                if (ma32 !== e.addr || mwe32 !== e.we[3:0] || mwd32 !== e.wdata[31:0]) begin
                    errors++;
                    $display("FAIL beat32: got addr=%h we=%b data=%h required addr=%h we=%b data=%h",
                             ma32, mwe32, mwd32, e.addr, e.we[3:0], e.wdata[31:0]);
                end
            end
        end
        if (!rst && mv64) begin
            checks++;
            if (q64.size() == 0) begin
                errors++;
                $display("FAIL beat64_unexpected: got addr=%h we=%b data=%h required none",
                         ma64, mwe64, mwd64);
            end else begin
                e = rdy64 ? q64.pop_front() : q64[0];
                if (ma64 !== e.addr || mwe64 !== e.we || mwd64 !== e.wdata) begin
                    errors++;
                    $display("FAIL beat64: got addr=%h we=%b data=%h required addr=%h we=%b data=%h",
                             ma64, mwe64, mwd64, e.addr, e.we, e.wdata);
                end
            end
        end
    end

    // Random back-pressure while rand_rdy is set.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) begin
                rdy32 = ($urandom_range(0, 3) != 0);
                rdy64 = ($urandom_range(0, 3) != 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rv32 = 1'b0; ra32 = '0; rs32 = '0; rd32 = '0; rdy32 = 1'b0;
        rv64 = 1'b0; ra64 = '0; rs64 = '0; rd64 = '0; rdy64 = 1'b0;
        #1;
        chk("rst_mem_valid", 64'(mv32), 64'd0);
        chk("rst_mem_we", 64'(mwe32), 64'd0);
        chk("rst_mem_addr", 64'(ma32), 64'd0);
        chk("rst_mem_wdata", 64'(mwd32), 64'd0);
        chk("rst_req_ready", 64'(rr32), 64'd1);
        chk("rst_empty", 64'(e32), 64'd1);
        chk("rst_mem_valid64", 64'(mv64), 64'd0);
        chk("rst_empty64", 64'(e64), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rdy32 = 1'b1;
        rdy64 = 1'b1;

        // Byte store at offset 3: one beat, next-cycle latency.
        send(1'b0, 32'h103, 2'd0, 64'hAB);
        chk("sb_latency", 64'(mv32), 64'd1);
        @(posedge clk); #1;
        chk("sb_empty_after", 64'(e32), 64'd1);

        // Word store crossing a word: two back-to-back beats, then empty.
        send(1'b0, 32'h203, 2'd2, 64'h11223344);
        chk("sw_split_latency", 64'(mv32), 64'd1);
        @(posedge clk); #1;
        chk("sw_beat1_follows", 64'(mv32), 64'd1);
        chk("sw_not_empty_in_beat1", 64'(e32), 64'd0);
        @(posedge clk); #1;
        chk("sw_empty_after", 64'(e32), 64'd1);

        // Half that fits in one word never splits; word wrapping past the top of memory.
        send(1'b0, 32'h302, 2'd1, 64'hCAFE);
        send(1'b0, 32'hFFFF_FFFE, 2'd2, 64'h55667788);
        send(1'b0, 32'h405, 2'd3, 64'hDEAD_BEEF_0102_0304);

        // 64-bit instance: half at offset 7 splits across dwords.
        send(1'b1, 32'h7, 2'd1, 64'hBEEF);
        send(1'b1, 32'h1C, 2'd3, 64'h0011_2233_4455_6677);
        wait_drain();

        // Fill under back-pressure, stall, then release for back-to-back beats.
        rdy32 = 1'b0;
        for (int i = 0; i < 4; i++) send(1'b0, 32'h1000 + 32'(4 * i), 2'd2, {32'h0, $urandom});
        chk("full_ready_low", 64'(rr32), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("stall_valid_held", 64'(mv32), 64'd1);
        rdy32 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("b2b_valid", 64'(mv32), 64'd1);
            @(posedge clk);
        end
        #1;
        chk("b2b_empty_after", 64'(e32), 64'd1);

        // Full with a pop in the same cycle: no bypass, accepted on the next cycle.
        rdy32 = 1'b0;
        for (int i = 0; i < 4; i++) send(1'b0, 32'h2000 + 32'(8 * i), 2'd1, {32'h0, $urandom});
        rv32 = 1'b1; ra32 = 32'h3001; rs32 = 2'd0; rd32 = 32'h5A;
        rdy32 = 1'b1;
        @(negedge clk);
        chk("full_no_bypass", 64'(rr32), 64'd0);
        @(posedge clk); #1;
        rdy32 = 1'b0;
        chk("ready_after_pop", 64'(rr32), 64'd1);
        @(negedge clk);
        if (rr32) expect_store(1'b0, 32'h3001, 2'd0, 64'h5A);
        @(posedge clk); #1;
        rv32 = 1'b0;
        rdy32 = 1'b1;
        wait_drain();

        // Randomised traffic on both instances with random back-pressure.
        rand_rdy = 1'b1;
        fork
            rand_run(1'b0, 150);
            rand_run(1'b1, 150);
        join
        rand_rdy = 1'b0;
        #1;
        rdy32 = 1'b1;
        rdy64 = 1'b1;
        wait_drain();
        chk("rand_empty32", 64'(e32), 64'd1);
        chk("rand_empty64", 64'(e64), 64'd1);

        // Reset while beat1 of a split store is on the port with another entry queued.
        rdy32 = 1'b0;
        send(1'b0, 32'h503, 2'd2, 64'h99AA_BBCC);
        send(1'b0, 32'h600, 2'd2, 64'h1234_5678);
        rdy32 = 1'b1;
        @(posedge clk); #1;
        rdy32 = 1'b0;
        chk("pre_rst_beat1_valid", 64'(mv32), 64'd1);
        chk("pre_rst_beat1_addr", 64'(ma32), 64'h504);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(mv32), 64'd0);
        chk("async_rst_empty", 64'(e32), 64'd1);
        chk("async_rst_ready", 64'(rr32), 64'd1);
        q32.delete();
        q64.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        rdy32 = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_no_beats", 64'(mv32), 64'd0);
        chk("post_rst_empty", 64'(e32), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/store_align_buf.md
Name: store_align_buf

Overview:
- Parametrised store unit between the LSU store path and the data RAM byte-lane write port.
- Buffers up to DEPTH store requests and aligns each one onto the RAM data width.
- Generates per-byte write enables for each store.
- A misaligned store that crosses a RAM word boundary is split into two RAM beats.

Parameters:
DW, 32, RAM data width in bits; legal values are 32 and 64.
AW, 32, byte address width.
DEPTH, 4, request FIFO entries; must be a power of two and at least 2.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous reset, active-high.
req_valid  in  1  store request valid.
req_ready  out  1  request accepted when req_valid and req_ready are both 1.
req_addr  in  AW  byte address; any alignment is allowed.
req_size  in  2  0=byte, 1=half, 2=word, 3=dword (dword only when DW=64).
req_wdata  in  DW  store data, right-justified (LSB = lowest byte).
mem_valid  out  1  RAM beat valid.
mem_ready  in  1  RAM accepts the beat when mem_valid and mem_ready are both 1.
mem_addr  out  AW  DW/8-aligned byte address; low log2(DW/8) bits are always 0.
mem_we  out  DW/8  per-byte write enables.
mem_wdata  out  DW  lane-aligned write data; bytes outside mem_we are 0.
empty  out  1  FIFO empty and no beat pending (used for fence/drain).

Behaviour:
- Reset values (immediately on rst high, asynchronously):
  - FIFO count = 0, read and write pointers = 0.
  - FSM = IDLE.
  - mem_valid = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - req_ready = 1, empty = 1.
  - Reset mid-beat discards all buffered stores; nothing is replayed.
- Size coercion:
  - NB = DW/8, OFF = req_addr mod NB.
  - With DW=32, req_size 3 is treated as size 2.
- Alignment is computed at issue time from the FIFO head:
  - mask2 = ((1<<(1<<size))-1) << OFF, 2*NB bits wide.
  - data2 = zero-extended data << (8*OFF), 2*DW bits wide.
  - Beat0: addr = addr & ~(NB-1); we = mask2[NB-1:0]; wdata = data2[DW-1:0].
  - Beat1 exists only if mask2[2NB-1:NB] != 0: addr = beat0 addr + NB (wraps modulo 2^AW); we = mask2 high half; wdata = data2 high half.
  - Data bytes not enabled in mask2 are forced to 0. Data bits of req_wdata above the access size are ignored.
- FIFO:
  - req_ready = (count != DEPTH). There is no bypass when full, even if a pop happens in the same cycle.
  - A push and a pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM:
  - IDLE: if count > 0, load beat0 from the head into the output registers, assert mem_valid and go to BEAT0.
  - BEAT0, on handshake:
    - If the head needs beat1, load beat1 and go to BEAT1 (mem_valid stays 1).
    - Otherwise pop the head. If count after the pop is > 0, load the next head's beat0 and stay in BEAT0 with no bubble. Else go to IDLE with mem_valid = 0.
  - BEAT1, on handshake: pop the head, then follow the same next-head rule as BEAT0.
  - mem_addr, mem_we and mem_wdata are registered and held stable while mem_valid=1 and mem_ready=0.
- Latency:
  - A request accepted in cycle N with an empty FIFO gives mem_valid=1 in cycle N+1.
  - With mem_ready tied to 1, an aligned store uses 1 beat and a split store uses 2 consecutive beats.
  - Sustained throughput is 1 beat per cycle.
- Ordering: beats leave in request order. Beat1 of a split store always immediately follows its beat0.
- empty = (count == 0) and (FSM == IDLE).
- Stores that fit entirely in one word never produce beat1, e.g. a half at OFF=2 with DW=32.

Test Plan:
1. DW=32, sb to addr 0x103 with data 0xAB, mem_ready=1 -> one beat: addr 0x100, we=1000, wdata=0xAB000000.
2. DW=32, sw to 0x203 with data 0x11223344 -> beat0: addr 0x200, we=1000, wdata 0x44000000; then beat1: addr 0x204, we=0111, wdata 0x00112233. The entry pops only after beat1.
3. DW=64, sh to 0x7 with data 0xBEEF -> beat0: addr 0x0, we=0x80, wdata[63:56]=0xEF; beat1: addr 0x8, we=0x01, wdata[7:0]=0xBE.
4. mem_ready=0, push 4 stores -> req_ready=0 after the 4th push. Then hold mem_ready=0 for 5 cycles -> mem outputs stay stable. Release mem_ready -> 4 beats issue back to back in order, and empty=1 on the cycle after the last handshake.
5. Push while full with a pop in the same cycle -> request not accepted; count stays DEPTH-1 after the pop, and the next cycle accepts.
6. Assert rst during BEAT1 of a split store with 2 entries queued -> mem_valid=0 and empty=1 immediately; after release, no residual beats are issued.
